// File: rtl/nn_result_tx.sv
// nn_result_tx: captures a final-layer result vector and serializes it onto tx AXI-Stream, one neuron per beat.
// Define NN_RESULT_ARGMAX_EN to append a beat carrying the index of the signed maximum.
module nn_result_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_OUTPUTS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUMBER_OF_OUTPUTS*DATA_WIDTH-1:0] res_data,
  input  logic                                    res_valid,
  output logic                                    res_ready,
  output logic [DATA_WIDTH-1:0]                   tx_tdata,
  output logic                                    tx_tvalid,
  output logic                                    tx_tlast,
  input  logic                                    tx_tready,
  output logic                                    busy
);
  localparam int N = NUMBER_OF_OUTPUTS;
  localparam int DW = DATA_WIDTH;
  localparam int IW = (N + 1 > 2) ? $clog2(N + 1) : 1;
`ifdef NN_RESULT_ARGMAX_EN
  localparam int LAST = N;
`else
  localparam int LAST = N - 1;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [DW-1:0] res_buf [N];
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] beat_n, data_n;
  logic cap, fire, done, valid_n, last_n, ready_n;
  assign cap = state == IDLE && res_valid && res_ready;
  assign fire = state == SEND && tx_tvalid && tx_tready;
  assign done = fire && tx_tlast;
`ifdef NN_RESULT_ARGMAX_EN
  logic [DW-1:0] max_q, max_n;
  logic [IW-1:0] win_q, win_n;
  logic take;
  // Ties keep the earlier index because only a strictly greater value wins.
  always_comb begin
    take = fire && idx < IW'(N) && (idx == '0 || $signed(tx_tdata) > $signed(max_q));
    max_n = cap ? '0 : take ? tx_tdata : max_q;
    win_n = cap ? '0 : take ? idx : win_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      max_q <= '0;
      win_q <= '0;
    end else begin
      max_q <= max_n;
      win_q <= win_n;
    end
`endif
  always_comb begin
    idx_n = (cap || done) ? '0 : fire ? idx + 1'b1 : idx;
    beat_n = '0;
    for (int i = 0; i < N; i++)
      if (idx_n == IW'(i)) beat_n = cap ? res_data[i*DW +: DW] : res_buf[i];
`ifdef NN_RESULT_ARGMAX_EN
    if (idx_n == IW'(N)) beat_n = DW'(win_n);
`endif
    state_n = cap ? SEND : done ? IDLE : state;
    valid_n = cap || (tx_tvalid && !done);
    data_n = done ? '0 : (cap || fire) ? beat_n : tx_tdata;
    last_n = (cap || fire) ? valid_n && idx_n == IW'(LAST) : tx_tlast;
    ready_n = (state == IDLE && !cap) || done;
  end
  always_ff @(posedge clk)
    if (cap)
      for (int i = 0; i < N; i++) res_buf[i] <= res_data[i*DW +: DW];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      tx_tvalid <= 1'b0;
      tx_tlast <= 1'b0;
      tx_tdata <= '0;
      res_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tx_tvalid <= valid_n;
      tx_tlast <= last_n;
      tx_tdata <= data_n;
      res_ready <= ready_n;
      busy <= valid_n;
    end
endmodule

// File: doc/nn_result_tx.md
Name: nn_result_tx

Overview:
Transmit end of the coprocessor's AXI-Stream data path. Captures the final-layer neuron output vector from the network core in one parallel transfer. Serializes it onto the tx AXI-Stream, one neuron per beat, and asserts tx_tlast on the last beat. It is the counterpart of the rx-side loader and drives the top-level tx_tdata, tx_tvalid, tx_tlast and tx_tready interface.

Parameters:
DATA_WIDTH, 32, width of one neuron result and of tx_tdata.
NUMBER_OF_OUTPUTS, 3, neurons in the final layer and beats per frame; legal range 1 to 256.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
res_data  input  NUMBER_OF_OUTPUTS*DATA_WIDTH  final-layer results; neuron i is at [i*DATA_WIDTH +: DATA_WIDTH]; signed two's complement.
res_valid  input  1  res_data is valid.
res_ready  output  1  block can capture a new result vector.
tx_tdata  output  DATA_WIDTH  stream data.
tx_tvalid  output  1  stream valid.
tx_tlast  output  1  last beat of the frame.
tx_tready  input  1  downstream ready.
busy  output  1  a frame is being held or sent.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, res_ready=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0, busy=0, beat index=0, buffer contents don't-care. On the first clk edge after rst deasserts, res_ready=1.
- FSM states:
  - IDLE: res_ready=1, busy=0. When res_valid && res_ready at edge k: latch the full res_data into the internal buffer, set beat index=0, go to SEND. res_ready=0 from edge k.
  - SEND: busy=1, tx_tvalid=1 starting in the cycle after edge k (capture-to-first-beat latency is 1 cycle). tx_tdata=buffer[index]. tx_tlast=1 only when index==NUMBER_OF_OUTPUTS-1 (or per the optional feature).
- Handshake rules:
  - A beat transfers on any edge where tx_tvalid && tx_tready; the index then increments.
  - While tx_tvalid && !tx_tready, tx_tdata and tx_tlast hold stable.
  - tx_tvalid never drops until the last beat has transferred.
  - A tx_tready that is high before tx_tvalid rises has no effect.
- End of frame: after the last beat transfers, go to IDLE. tx_tvalid=0, tx_tlast=0 and res_ready=1 in the next cycle, so there is exactly one idle cycle between frames.
- Input changes during a frame: res_valid while busy is ignored (res_ready=0). Changes on res_data after capture have no effect on the frame in progress.
- Full-rate transfer: with tx_tready held at 1, the N beats occupy N consecutive cycles.
- NUMBER_OF_OUTPUTS=1: a single beat with tx_tlast=1.
- Index counter: $clog2(NUMBER_OF_OUTPUTS+1) bits, with a minimum of 1.
- Reset mid-frame: tx_tvalid falls asynchronously. The partial frame is discarded and is not resumed after reset.
- tx_tdata is registered. No combinational path exists from tx_tready to tx_tvalid or tx_tdata.

Optional Feature:
Macro: NN_RESULT_ARGMAX_EN.
- Defined:
  - During SEND, the block tracks a running signed maximum and its index, updated as each beat is accepted. Ties keep the lowest index.
  - After the last result beat, one extra beat is sent: tx_tdata = the winning index, zero-extended to DATA_WIDTH, with tx_tlast=1.
  - tx_tlast on the last result beat is then 0, and a frame is NUMBER_OF_OUTPUTS+1 beats.
  - The tracked maximum and index clear on capture.
- Undefined: none of this logic is present, and a frame is exactly NUMBER_OF_OUTPUTS beats.

Test Plan:
1. Reset release, tx_tready=1, capture {neuron2=0x30, neuron1=0x20, neuron0=0x10} -> beats 0x10, 0x20, 0x30 on 3 consecutive cycles starting 1 cycle after capture; tx_tlast only on 0x30; res_ready=1 one cycle after the last beat.
2. Same vector, tx_tready toggled 1,0,0,1,0,1 -> tx_tdata and tx_tlast stable during stalls; beats in order; no beat lost or duplicated.
3. res_valid held high with a new vector {0xA, 0xB, 0xC} during frame 1 -> ignored until IDLE; then captured and sent as frame 2 after exactly one idle cycle.
4. rst asserted after the second beat is accepted -> tx_tvalid=0 and busy=0 immediately; after release only a new capture produces output, and the first beat is index 0.
5. NN_RESULT_ARGMAX_EN defined, vector {0xFFFFFFFF(-1), 0x00000005, 0x00000005} -> beats -1, 5, 5, then 0x00000001 with tx_tlast; tx_tlast=0 on the third beat.
6. NUMBER_OF_OUTPUTS=1, value 0x7 -> single beat 0x7 with tx_tlast=1; res_ready back to 1 on the following cycle.
